// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder (LSB first) with IDLE/ADD/DONE control; optional subtract via SERIAL_ADDER_SUB_EN
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r, sum_nxt;
  logic [CW-1:0]    cnt;
  logic             c_int, carry_r;
  logic             sub_i;
  logic             ha1_s, ha1_c, ha2_c, fa_s, fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  // Full-adder cell: two half-adder stages, carries merged with an OR.
  always_comb begin
    ha1_s = a_sh[0] ^ b_sh[0];
    ha1_c = a_sh[0] & b_sh[0];
    fa_s  = ha1_s ^ c_int;
    ha2_c = ha1_s & c_int;
    fa_co = ha1_c | ha2_c;
  end

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    sum_nxt             = sum_r >> 1;
    sum_nxt[WIDTH-1]    = fa_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and one-hot status outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand load on accept, one bit per cycle while adding.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      c_int   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh    <= a;
          b_sh    <= sub_i ? ~b : b;
          sum_r   <= '0;
          carry_r <= 1'b0;
          c_int   <= sub_i;
          cnt     <= '0;
        end
        ADD: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum_r <= sum_nxt;
          c_int <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) carry_r <= fa_co;
        end
        default: ;
      endcase
    end
  end

  assign sum   = sum_r;
  assign carry = carry_r;

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request to begin an operation; accepted only when ready=1.
REQ-005 Port: a  input  WIDTH  operand A; sampled on the accepting edge only.
REQ-006 Port: b  input  WIDTH  operand B; sampled on the accepting edge only.
REQ-007 Port: ready  output  1  high only in IDLE.
REQ-008 Port: busy  output  1  high only in ADD.
REQ-009 Port: done  output  1  one-cycle pulse marking a valid result.
REQ-010 Port: sum  output  WIDTH  result; held from DONE until the next accepting edge.
REQ-011 Port: carry  output  1  carry out of bit WIDTH-1; held with sum.

Function
REQ-012 The block SHALL compute a+b bit-serially, LSB first, one bit per cycle, using one 1-bit full-adder cell built from two half-adder stages plus an OR of their carries.
REQ-013 The FSM SHALL have exactly three states: IDLE, ADD and DONE, all registered.
REQ-014 IDLE: start=1 at an edge SHALL load a and b into shift registers, clear the bit counter and internal carry to 0, clear sum and carry outputs to 0, and move to ADD.
REQ-015 ADD: each edge SHALL add the current LSBs with the internal carry, shift the sum bit in at the MSB of the sum register, update the internal carry, and increment the counter.
REQ-016 ADD SHALL move to DONE on the edge that processes bit WIDTH-1, so WIDTH edges are spent in ADD.
REQ-017 DONE SHALL assert done for exactly one cycle with final sum and carry valid, then return to IDLE unconditionally.
REQ-018 Latency: done SHALL be high in the cycle following the WIDTH-th edge after the accepting edge.
REQ-019 Back-to-back: start=1 in the first IDLE cycle after DONE SHALL be accepted, giving throughput of one result per WIDTH+2 cycles.
REQ-020 start while in ADD or DONE SHALL be ignored, with no effect on state, operands or result.
REQ-021 Changes on a and b after the accepting edge SHALL NOT affect the result.
REQ-022 Overflow: carry SHALL equal bit WIDTH of the true (WIDTH+1)-bit sum; sum SHALL wrap modulo 2^WIDTH.
REQ-023 WIDTH=1: ADD SHALL last exactly one cycle with correct sum and carry.
REQ-024 ready, busy and done SHALL be mutually exclusive and always one-hot.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE from any state, including mid-ADD, and discard the in-flight operation.
REQ-026 Reset values: ready=1, busy=0, done=0, sum=0, carry=0, counter=0, internal carry=0.
REQ-027 start asserted together with rst SHALL be ignored; acceptance is possible from the first edge with rst=0.

Configuration
REQ-028 Macro SERIAL_ADDER_SUB_EN, when defined, SHALL add port "sub input 1", sampled on the accepting edge.
REQ-029 With SERIAL_ADDER_SUB_EN defined and sub=1, the block SHALL compute a-b as a+~b+1 (internal carry preset to 1, b inverted at load); carry=1 means no borrow.
REQ-030 Without SERIAL_ADDER_SUB_EN, the sub port SHALL NOT exist and the block SHALL perform addition only, with no change in timing.

Verification (WIDTH=8)
REQ-031 rst=1 for 2 cycles -> ready=1, busy=0, done=0, sum=8'h00, carry=0.
REQ-032 start with a=8'h0F, b=8'h01 -> busy for 8 cycles, then done pulse with sum=8'h10, carry=0.
REQ-033 start with a=8'hFF, b=8'h01 -> sum=8'h00, carry=1. Then a=8'hFF, b=8'hFF issued back-to-back -> sum=8'hFE, carry=1.
REQ-034 start with a=8'h12, b=8'h34, then start pulsed in ADD and a/b changed to 8'hFF -> single done, sum=8'h46, carry=0.
REQ-035 rst=1 during the 4th ADD cycle -> IDLE next cycle, no done pulse, sum=0. A new op a=8'h01, b=8'h02 -> sum=8'h03.
REQ-036 SERIAL_ADDER_SUB_EN defined, sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, carry=0. Then a=8'h07, b=8'h05 -> sum=8'h02, carry=1.
